ddr3_rd_sched: RTL and testbench

DDR3_RD_SCHED -- requirements
Module: ddr3_rd_sched

---
 rtl/ddr3_pkg.sv | 19 +
 rtl/ddr3_out_cnt.sv | 29 ++
 rtl/ddr3_rd_sched.sv | 156 +++++++++++++++
 tb/tb_ddr3_rd_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 read scheduler: state encoding, default sizing
// and the DDR3 word address / data widths.
package ddr3_pkg;

  localparam int ADDR_W        = 26;
  localparam int DATA_W        = 128;
  localparam int BUF_WORDS_DEF = 1200;
  localparam int MAX_OUT_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    BUF_RD,
    BUF_DRAIN,
    TEST_WR,
    TEST_RD,
    TEST_WAIT
  } state_t;

endpackage

// File: rtl/ddr3_out_cnt.sv
// Outstanding DDR3 read counter: +1 per accepted read, -1 per returned word,
// saturating at 0 and MAX_OUT.
module ddr3_out_cnt #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == CNT_W'(MAX_OUT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (!at_max) count <= count + CNT_W'(1);
        2'b01:   if (count != '0) count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_rd_sched.sv
// DDR3 read scheduler: streams full frames from two ping-pong buffers into the
// pixel FIFO, interleaved with single-word test write/read accesses.
module ddr3_rd_sched
  import ddr3_pkg::*;
#(
  parameter int BUF_WORDS = BUF_WORDS_DEF,
  parameter int MAX_OUT   = MAX_OUT_DEF
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset_n,
  input  logic              buf0_full,
  input  logic              buf1_full,
  input  logic [ADDR_W-1:0] buf0_offset,
  input  logic [ADDR_W-1:0] buf1_offset,
  output logic              clear_buffer0,
  output logic              clear_buffer1,
  input  logic              test_wr,
  input  logic              test_rd,
  input  logic [ADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0] test_wr_data,
  output logic [DATA_W-1:0] test_rd_data,
  output logic              wr_finish,
  output logic              rd_finish,
  output logic              avl_read,
  output logic              avl_write,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic              avl_ready,
  input  logic [DATA_W-1:0] avl_rdata,
  input  logic              avl_rdata_valid,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_afull
);

  localparam int ISS_W = $clog2(BUF_WORDS + 1);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [ISS_W-1:0] ISS_END = ISS_W'(BUF_WORDS);

  state_t            state, state_nxt;
  logic              nxt;
  logic [ISS_W-1:0]  issued;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              wr_pend, rd_pend, rd_hold;
  logic [CNT_W-1:0]  out_count;
  logic              out_at_max;
  logic              buf_state, buf_accept, cnt_dec, leave_idle, drain_done;

  assign buf_state  = (state == BUF_RD) || (state == BUF_DRAIN);
  assign buf_accept = (state == BUF_RD) && avl_read && avl_ready;
  assign cnt_dec    = buf_state && avl_rdata_valid;
  assign leave_idle = (state == IDLE) && (state_nxt != IDLE);
  assign drain_done = (state == BUF_DRAIN) && (out_count == '0);

  ddr3_out_cnt #(
    .MAX_OUT(MAX_OUT),
    .CNT_W  (CNT_W)
  ) u_out_cnt (
    .clk    (ddr3_clk),
    .reset_n(ddr3_reset_n),
    .inc    (buf_accept),
    .dec    (cnt_dec),
    .count  (out_count),
    .at_max (out_at_max)
  );

  always_comb begin
    state_nxt     = state;
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    avl_addr      = '0;
    avl_wdata     = '0;
    clear_buffer0 = 1'b0;
    clear_buffer1 = 1'b0;
    wr_finish     = 1'b0;
    rd_finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_pend)                          state_nxt = TEST_WR;
        else if (rd_pend)                     state_nxt = TEST_RD;
        else if (nxt ? buf1_full : buf0_full) state_nxt = BUF_RD;
      end
      BUF_RD: begin
        // rd_hold keeps a refused request up even if fifo_afull rises meanwhile
        avl_read = rd_hold || ((issued != ISS_END) && !out_at_max && !fifo_afull);
        avl_addr = base + ADDR_W'(issued);
        if (issued == ISS_END) state_nxt = BUF_DRAIN;
      end
      BUF_DRAIN: begin
        if (out_count == '0) begin
          clear_buffer0 = !nxt;
          clear_buffer1 = nxt;
          state_nxt     = IDLE;
        end
      end
      TEST_WR: begin
        avl_write = 1'b1;
        avl_addr  = t_addr;
        avl_wdata = t_wdata;
        if (avl_ready) begin
          wr_finish = 1'b1;
          state_nxt = IDLE;
        end
      end
      TEST_RD: begin
        avl_read = 1'b1;
        avl_addr = t_addr;
        if (avl_ready) state_nxt = TEST_WAIT;
      end
      TEST_WAIT: begin
        if (avl_rdata_valid) begin
          rd_finish = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3_reset_n) begin
      state        <= IDLE;
      nxt          <= 1'b0;
      issued       <= '0;
      base         <= '0;
      t_addr       <= '0;
      t_wdata      <= '0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_hold      <= 1'b0;
      fifo_wr      <= 1'b0;
      fifo_data    <= '0;
      test_rd_data <= '0;
    end else begin
      state   <= state_nxt;
      // a new pulse wins over the clear so a request in the entry cycle survives
      wr_pend <= test_wr || (wr_pend && !(leave_idle && state_nxt == TEST_WR));
      rd_pend <= test_rd || (rd_pend && !(leave_idle && state_nxt == TEST_RD));
      rd_hold <= (state == BUF_RD) && avl_read && !avl_ready;
      if (leave_idle) begin
        base    <= nxt ? buf1_offset : buf0_offset;
        issued  <= '0;
        t_addr  <= test_addr;
        t_wdata <= test_wr_data;
      end
      if (buf_accept) issued <= issued + ISS_W'(1);
      if (drain_done) nxt <= !nxt;
      fifo_wr <= cnt_dec;
      if (cnt_dec) fifo_data <= avl_rdata;
      if ((state == TEST_WAIT) && avl_rdata_valid) test_rd_data <= avl_rdata;
    end
  end

endmodule

// File: tb/tb_ddr3_rd_sched.sv
// Bench for ddr3_rd_sched: randomized Avalon memory responder plus a frame-level
// reference model of buffer readout order, addresses, data and test accesses.
module tb_ddr3_rd_sched;

  localparam int BW = 12;
  localparam int MO = 8;

  logic          ddr3_clk;
  logic          ddr3_reset_n;
  logic          buf0_full, buf1_full;
  logic [25:0]   buf0_offset, buf1_offset;
  logic          clear_buffer0, clear_buffer1;
  logic          test_wr, test_rd;
  logic [25:0]   test_addr;
  logic [127:0]  test_wr_data, test_rd_data;
  logic          wr_finish, rd_finish;
  logic          avl_read, avl_write, avl_ready, avl_rdata_valid;
  logic [25:0]   avl_addr;
  logic [127:0]  avl_wdata, avl_rdata;
  logic          fifo_wr, fifo_afull;
  logic [127:0]  fifo_data;

  ddr3_rd_sched #(.BUF_WORDS(BW), .MAX_OUT(MO)) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
    .buf0_full(buf0_full), .buf1_full(buf1_full),
    .buf0_offset(buf0_offset), .buf1_offset(buf1_offset),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .test_wr(test_wr), .test_rd(test_rd), .test_addr(test_addr),
    .test_wr_data(test_wr_data), .test_rd_data(test_rd_data),
    .wr_finish(wr_finish), .rd_finish(rd_finish),
    .avl_read(avl_read), .avl_write(avl_write), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_ready(avl_ready), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid),
    .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_afull(fifo_afull)
  );

  initial begin
    ddr3_clk = 1'b0;
    forever #5 ddr3_clk = ~ddr3_clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0 random, 1 always ready, 2 never ready
  int resp_mode = 0;    // 0 random returns, 1 no returns, 2 exactly one return
  int n_acc = 0, n_ret = 0;
  bit track = 1'b1;

  logic [25:0]  ret_q[$];
  logic [25:0]  rd_log[$];
  logic [127:0] fifo_log[$];
  logic [25:0]  wr_addr_log[$];
  logic [127:0] wr_data_log[$];
  int clr0_cyc[$], clr1_cyc[$], wr_cyc[$], wrfin_cyc[$], rdfin_cyc[$];

  logic         p_pend, p_read, p_write;
  logic [25:0]  p_addr;
  logic [127:0] p_wdata;

  function automatic logic [127:0] mem_f(logic [25:0] a);
    if (a == 26'h2A) return 128'hDEADBEEF;
    return {6'h11, a, 6'h22, ~a, 6'h33, a + 26'd7, 6'h3C, a ^ 26'h2AAAAAA};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder and bus monitor: drive at negedge, observe 2 time units later.
  initial begin
    avl_ready = 1'b0;
    avl_rdata_valid = 1'b0;
    avl_rdata = '0;
    p_pend = 1'b0;
    forever begin
      @(negedge ddr3_clk);
      cyc++;
      avl_ready = (ready_mode == 1) || (ready_mode == 0 && $urandom_range(0, 3) != 0);
      avl_rdata_valid = 1'b0;
      avl_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (ret_q.size() != 0 && (resp_mode == 2 || (resp_mode == 0 && $urandom_range(0, 2) != 0))) begin
        avl_rdata = mem_f(ret_q.pop_front());
        avl_rdata_valid = 1'b1;
        n_ret++;
        if (resp_mode == 2) resp_mode = 1;
      end
      #2;
      if (!ddr3_reset_n) begin
        p_pend = 1'b0;
      end else begin
        if (avl_read || avl_write) chk("rd_wr_exclusive", avl_read & avl_write, 0);
        if (p_pend) begin
          chk("cmd_stable_ctl", {avl_read, avl_write, avl_addr}, {p_read, p_write, p_addr});
          chk("cmd_stable_wdata", avl_wdata, p_wdata);
        end
        p_pend  = (avl_read || avl_write) && !avl_ready;
        p_read  = avl_read;
        p_write = avl_write;
        p_addr  = avl_addr;
        p_wdata = avl_wdata;
        if (avl_read && avl_ready) begin
          if (track) chk("outstanding_limit", (n_acc - (n_ret - int'(avl_rdata_valid))) < MO, 1);
          rd_log.push_back(avl_addr);
          ret_q.push_back(avl_addr);
          n_acc++;
        end
        if (avl_write && avl_ready) begin
          wr_addr_log.push_back(avl_addr);
          wr_data_log.push_back(avl_wdata);
          wr_cyc.push_back(cyc);
        end
        if (fifo_wr) fifo_log.push_back(fifo_data);
        if (clear_buffer0) clr0_cyc.push_back(cyc);
        if (clear_buffer1) clr1_cyc.push_back(cyc);
        if (wr_finish) wrfin_cyc.push_back(cyc);
        if (rd_finish) rdfin_cyc.push_back(cyc);
      end
    end
  end

  // Frame source releases a buffer as soon as it is cleared.
  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge ddr3_clk);
      #1;
      if (clear_buffer0) buf0_full = 1'b0;
      if (clear_buffer1) buf1_full = 1'b0;
    end
  endtask

  function automatic int cnt(int sel);
    case (sel)
      0:       return clr0_cyc.size();
      1:       return clr1_cyc.size();
      2:       return rd_log.size();
      3:       return wrfin_cyc.size();
      4:       return rdfin_cyc.size();
      default: return fifo_log.size();
    endcase
  endfunction

  task automatic wait_cnt(int sel, int want, string tag);
    int n = 0;
    while (cnt(sel) < want && n < 4000) begin
      step(1);
      n++;
    end
    chk(tag, cnt(sel), want);
  endtask

  task automatic clear_logs();
    rd_log.delete(); fifo_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    clr0_cyc.delete(); clr1_cyc.delete(); wr_cyc.delete(); wrfin_cyc.delete(); rdfin_cyc.delete();
  endtask

  // Expected frame: BW consecutive word reads from off (mod 2^26), each forwarded in order.
  task automatic chk_buf(string tag, logic [25:0] off, int first);
    for (int i = 0; i < BW; i++) begin
      logic [25:0] a;
      int idx;
      a = off + 26'(i);
      idx = first + i;
      chk($sformatf("%s_addr%0d", tag, i), (idx < rd_log.size()) ? 128'(rd_log[idx]) : 'x, 128'(a));
      chk($sformatf("%s_data%0d", tag, i), (idx < fifo_log.size()) ? fifo_log[idx] : 'x, mem_f(a));
    end
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_cmd"}, {avl_read, avl_write, avl_addr}, 0);
    chk({tag, "_wdata"}, avl_wdata, 0);
    chk({tag, "_pulses"}, {fifo_wr, clear_buffer0, clear_buffer1, wr_finish, rd_finish}, 0);
    chk({tag, "_fifo_data"}, fifo_data, 0);
    chk({tag, "_test_rd_data"}, test_rd_data, 0);
  endtask

  initial begin
    logic [25:0]  off0, off1, ta;
    logic [127:0] td;
    int n;

    ddr3_reset_n = 1'b0;
    buf0_full = 1'b0; buf1_full = 1'b0; buf0_offset = '0; buf1_offset = '0;
    test_wr = 1'b0; test_rd = 1'b0; test_addr = '0; test_wr_data = '0; fifo_afull = 1'b0;

    // Reset state
    step(3);
    chk_quiet("reset");
    ddr3_reset_n = 1'b1;
    step(2);
    chk_quiet("idle");

    // Single buffer readout at 0x100
    off0 = 26'h100;
    buf0_offset = off0;
    buf0_full = 1'b1;
    wait_cnt(0, 1, "s1_clear0");
    step(5);
    chk("s1_clear0_once", cnt(0), 1);
    chk("s1_clear1_none", cnt(1), 0);
    chk("s1_reads", cnt(2), BW);
    chk("s1_fifo_writes", cnt(5), BW);
    chk_buf("s1", off0, 0);

    // Both buffers full after reset: buf0 then buf1, buf1 range wraps at 2^26
    ddr3_reset_n = 1'b0;
    step(3);
    ddr3_reset_n = 1'b1;
    n_acc = 0; n_ret = 0;
    clear_logs();
    off0 = 26'($urandom);
    off1 = 26'h3FFFFFA;
    buf0_offset = off0; buf1_offset = off1;
    buf0_full = 1'b1; buf1_full = 1'b1;
    wait_cnt(1, 1, "s2_clear1");
    step(5);
    chk("s2_clear0_once", cnt(0), 1);
    chk("s2_clear_order", clr0_cyc[0] < clr1_cyc[0], 1);
    chk("s2_reads", cnt(2), 2 * BW);
    chk_buf("s2_b0", off0, 0);
    chk_buf("s2_b1", off1, BW);

    // Pointer back at buf0: buf1 alone is not served out of turn
    clear_logs();
    off1 = 26'($urandom);
    buf1_offset = off1;
    buf1_full = 1'b1;
    step(40);
    chk("s3_buf1_waits", cnt(2), 0);

    // Outstanding limit: no returns, then a single return frees one slot
    resp_mode = 1;
    ready_mode = 1;
    off0 = 26'($urandom);
    buf0_offset = off0;
    buf0_full = 1'b1;
    step(40);
    chk("s3_reads_at_limit", cnt(2), MO);
    chk("s3_read_low_at_limit", avl_read, 0);
    resp_mode = 2;
    step(12);
    chk("s3_one_more_read", cnt(2), MO + 1);
    chk("s3_read_low_again", avl_read, 0);
    resp_mode = 0;
    ready_mode = 0;
    wait_cnt(1, 1, "s3_clear1");
    step(5);
    chk("s3_clear0_once", cnt(0), 1);
    chk("s3_clear_order", clr0_cyc[0] < clr1_cyc[0], 1);
    chk_buf("s3_b0", off0, 0);
    chk_buf("s3_b1", off1, BW);

    // Test write requested mid-readout is served after the buffer completes
    clear_logs();
    off0 = 26'($urandom);
    buf0_offset = off0;
    buf0_full = 1'b1;
    wait_cnt(2, 1, "s4_first_read");
    ta = 26'($urandom);
    td = {$urandom, $urandom, $urandom, $urandom};
    test_addr = ta; test_wr_data = td;
    test_wr = 1'b1;
    step(1);
    test_wr = 1'b0;
    n = 0;
    while (!wr_finish && n < 4000) begin
      step(1);
      n++;
    end
    chk("s4_wr_finish_seen", wr_finish, 1);
    // test read requested during the write's completing cycle
    test_addr = 26'h2A;
    test_rd = 1'b1;
    step(1);
    test_rd = 1'b0;
    chk("s4_wr_count", wr_addr_log.size(), 1);
    chk("s4_wr_addr", wr_addr_log[0], ta);
    chk("s4_wr_data", wr_data_log[0], td);
    chk("s4_clear0", cnt(0), 1);
    chk("s4_wr_after_clear", wr_cyc[0] > clr0_cyc[0], 1);
    chk("s4_wrfin_cycle", wrfin_cyc[0], wr_cyc[0]);
    chk_buf("s4", off0, 0);

    // Test read at 0x2A
    wait_cnt(4, 1, "s5_rd_finish");
    step(3);
    chk("s5_rd_data", test_rd_data, 128'hDEADBEEF);
    chk("s5_rd_addr", rd_log[BW], 26'h2A);
    chk("s5_rd_count", cnt(2), BW + 1);
    chk("s5_no_fifo_wr", cnt(5), BW);
    chk("s5_wrfin_once", cnt(3), 1);
    chk("s5_rdfin_once", cnt(4), 1);

    // Random test read
    clear_logs();
    ta = 26'($urandom) | 26'h2000000;
    test_addr = ta;
    test_rd = 1'b1;
    step(1);
    test_rd = 1'b0;
    wait_cnt(4, 1, "s5r_rd_finish");
    step(3);
    chk("s5r_rd_data", test_rd_data, mem_f(ta));
    chk("s5r_rd_addr", rd_log[0], ta);
    chk("s5r_no_fifo_wr", cnt(5), 0);
    chk("s5r_rdfin_once", cnt(4), 1);

    // Stall, FIFO back-pressure, then reset mid-readout (pointer now on buf1)
    clear_logs();
    ready_mode = 2;
    off1 = 26'($urandom);
    buf1_offset = off1;
    buf1_full = 1'b1;
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s6_stall_read%0d", i), avl_read, 1);
      chk($sformatf("s6_stall_addr%0d", i), avl_addr, off1);
      step(1);
    end
    fifo_afull = 1'b1;
    ready_mode = 1;
    step(4);
    chk("s6_afull_one_read", cnt(2), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s6_afull_read_low%0d", i), avl_read, 0);
      step(1);
    end
    fifo_afull = 1'b0;
    ready_mode = 0;
    wait_cnt(2, 4, "s6_resume");
    ddr3_reset_n = 1'b0;
    track = 1'b0;
    buf1_full = 1'b0;
    chk("s6_mid_transfer", cnt(2) < BW, 1);
    step(2);
    ddr3_reset_n = 1'b1;
    fifo_log.delete();
    step(1);
    chk_quiet("s6_after_reset");
    step(30);
    chk("s6_no_clear0", cnt(0), 0);
    chk("s6_no_clear1", cnt(1), 0);
    chk("s6_stale_ignored", cnt(5), 0);
    chk_quiet("s6_quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
